// File: rtl/mem_read_responder_if.sv
// Request/response bus between a requester and mem_read_responder; one request per cycle,
// read data returns on data_valid with no back-pressure in either direction.
interface mem_read_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy
  );
endinterface

// File: rtl/mem_read_responder.sv
// Backing memory: writes commit at the request edge, reads return LATENCY cycles after issue.
// Accepts one request every cycle and never stalls the requester.
module mem_read_responder #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int WORD_AW = 13
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_read_responder_if.slave bus
);

  localparam int Depth = 1 << WORD_AW;

  logic [DATA_W-1:0]  mem_q [Depth];
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [WORD_AW-1:0] idx;
  logic               wr_req;
  logic               rd_req;
  logic               busy_d;
  logic               unused_addr;

  // Byte-address bit 0 and bits above the array index alias onto the same word.
  assign idx         = bus.addr[WORD_AW:1];
  assign unused_addr = ^{bus.addr[0], bus.addr[ADDR_W-1:WORD_AW+1]};

  assign wr_req = bus.enable & bus.wr & ~rst_i;
  assign rd_req = bus.enable & ~bus.wr & ~rst_i;

  // Read data is snapshotted at issue, so later writes never disturb in-flight reads.
  always_ff @(posedge clk_i) begin
    if (wr_req) begin
      mem_q[idx] <= bus.data_in;
    end
    if (rd_req) begin
      dat_q[0] <= mem_q[idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = rd_req;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // The output stage is excluded: a read presenting its data is no longer in flight.
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      busy_d = busy_d | vld_q[i];
    end
  end

  assign bus.busy       = busy_d;
  assign bus.data_valid = vld_q[LATENCY-1];
  assign bus.data_out   = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : '0;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_mem_read_responder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_read_responder_if #(.DATA_W(16), .ADDR_W(16)) bus4 ();
  mem_read_responder_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  mem_read_responder #(.LATENCY(4), .DATA_W(16), .ADDR_W(16), .WORD_AW(13)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  mem_read_responder #(.LATENCY(1), .DATA_W(16), .ADDR_W(16), .WORD_AW(13)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus4.enable  = en;
    bus4.wr      = w;
    bus4.addr    = a;
    bus4.data_in = d;
  endtask

  task automatic drv1(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus1.enable  = en;
    bus1.wr      = w;
    bus1.addr    = a;
    bus1.data_in = d;
  endtask

  task automatic idle4();
    bus4.enable  = 1'b0;
    bus4.wr      = 1'bx;
    bus4.addr    = 'x;
    bus4.data_in = 'x;
  endtask

  task automatic idle1();
    bus1.enable  = 1'b0;
    bus1.wr      = 1'bx;
    bus1.addr    = 'x;
    bus1.data_in = 'x;
  endtask

  task automatic drain(input int n);
    idle4();
    idle1();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [15:0] exp_d;
    logic        exp_v;
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    idle4();
    idle1();
    tick();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_dv4", {15'd0, bus4.data_valid}, 16'd0);
    chk("rst_do4", bus4.data_out, 16'h0000);
    chk("rst_busy4", {15'd0, bus4.busy}, 16'd0);
    chk("rst_dv1", {15'd0, bus1.data_valid}, 16'd0);
    chk("rst_do1", bus1.data_out, 16'h0000);

    // Test 1: write then read-after-write, latency 4
    for (int c = 0; c <= 6; c++) begin
      case (c)
        0:       drv4(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        1:       drv4(1'b1, 1'b0, 16'h0010, 16'h0000);
        default: idle4();
      endcase
      if (c >= 2) begin
        exp_v = (c == 5);
        exp_d = (c == 5) ? 16'hBEEF : 16'h0000;
        chk($sformatf("t1_dv_c%0d", c), {15'd0, bus4.data_valid}, {15'd0, exp_v});
        chk($sformatf("t1_do_c%0d", c), bus4.data_out, exp_d);
      end
      tick();
    end
    drain(5);

    // Test 2: four back-to-back reads stream out in order
    drv4(1'b1, 1'b1, 16'h0000, 16'h00A0); tick();
    drv4(1'b1, 1'b1, 16'h0002, 16'h00A1); tick();
    drv4(1'b1, 1'b1, 16'h0004, 16'h00A2); tick();
    drv4(1'b1, 1'b1, 16'h0006, 16'h00A3); tick();
    for (int c = 0; c <= 8; c++) begin
      if (c <= 3) drv4(1'b1, 1'b0, 16'(2 * c), 16'h0000);
      else        idle4();
      exp_v = (c >= 4) && (c <= 7);
      exp_d = exp_v ? 16'(16'h00A0 + c - 4) : 16'h0000;
      chk($sformatf("t2_dv_c%0d", c), {15'd0, bus4.data_valid}, {15'd0, exp_v});
      chk($sformatf("t2_do_c%0d", c), bus4.data_out, exp_d);
      if (c <= 4) chk($sformatf("t2_busy_c%0d", c), {15'd0, bus4.busy}, {15'd0, (c >= 1)});
      tick();
    end
    drain(5);

    // Test 3: read snapshot survives a following write; later read sees new value
    drv4(1'b1, 1'b1, 16'h0020, 16'h1111); tick();
    for (int c = 0; c <= 7; c++) begin
      case (c)
        0:       drv4(1'b1, 1'b0, 16'h0020, 16'h0000);
        1:       drv4(1'b1, 1'b1, 16'h0020, 16'h2222);
        2:       drv4(1'b1, 1'b0, 16'h0020, 16'h0000);
        default: idle4();
      endcase
      if (c >= 1) begin
        exp_v = (c == 4) || (c == 6);
        exp_d = (c == 4) ? 16'h1111 : (c == 6) ? 16'h2222 : 16'h0000;
        chk($sformatf("t3_dv_c%0d", c), {15'd0, bus4.data_valid}, {15'd0, exp_v});
        chk($sformatf("t3_do_c%0d", c), bus4.data_out, exp_d);
      end
      tick();
    end
    drain(5);

    // Test 4: reset drops in-flight reads and blocks a same-cycle write
    for (int c = 0; c <= 8; c++) begin
      rst = (c == 2);
      case (c)
        0:       drv4(1'b1, 1'b0, 16'h0010, 16'h0000);
        1:       drv4(1'b1, 1'b0, 16'h0000, 16'h0000);
        2:       drv4(1'b1, 1'b1, 16'h0010, 16'hDEAD);
        default: idle4();
      endcase
      if (c == 2) chk("t4_busy_inflight", {15'd0, bus4.busy}, 16'd1);
      if (c >= 3) begin
        chk($sformatf("t4_dv_c%0d", c), {15'd0, bus4.data_valid}, 16'd0);
        chk($sformatf("t4_busy_c%0d", c), {15'd0, bus4.busy}, 16'd0);
      end
      tick();
    end
    rst = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      case (c)
        0:       drv4(1'b1, 1'b0, 16'h0010, 16'h0000);
        1:       drv4(1'b1, 1'b0, 16'h0000, 16'h0000);
        default: idle4();
      endcase
      if (c == 4) chk("t4_reread_10", bus4.data_out, 16'hBEEF);
      if (c == 5) chk("t4_reread_00", bus4.data_out, 16'h00A0);
      tick();
    end
    drain(3);

    // Test 5: address aliasing on bit 0 and bits above the index
    drv4(1'b1, 1'b1, 16'h0031, 16'h5A5A); tick();
    for (int c = 0; c <= 6; c++) begin
      case (c)
        0:       drv4(1'b1, 1'b0, 16'h0030, 16'h0000);
        1:       drv4(1'b1, 1'b0, 16'h4030, 16'h0000);
        default: idle4();
      endcase
      if (c == 4 || c == 5) begin
        chk($sformatf("t5_dv_c%0d", c), {15'd0, bus4.data_valid}, 16'd1);
        chk($sformatf("t5_do_c%0d", c), bus4.data_out, 16'h5A5A);
      end
      if (c == 6) chk("t5_dv_end", {15'd0, bus4.data_valid}, 16'd0);
      tick();
    end
    drain(3);

    // Test 6: LATENCY=1 instance streams one read per cycle
    drv1(1'b1, 1'b1, 16'h0100, 16'h1234); tick();
    drv1(1'b1, 1'b1, 16'h0102, 16'h5678); tick();
    for (int c = 0; c <= 3; c++) begin
      case (c)
        0:       drv1(1'b1, 1'b0, 16'h0100, 16'h0000);
        1:       drv1(1'b1, 1'b0, 16'h0102, 16'h0000);
        default: idle1();
      endcase
      exp_v = (c == 1) || (c == 2);
      exp_d = (c == 1) ? 16'h1234 : (c == 2) ? 16'h5678 : 16'h0000;
      chk($sformatf("t6_dv_c%0d", c), {15'd0, bus1.data_valid}, {15'd0, exp_v});
      chk($sformatf("t6_do_c%0d", c), bus1.data_out, exp_d);
      chk($sformatf("t6_busy_c%0d", c), {15'd0, bus1.busy}, 16'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
